// File: rtl/nios_adc_key_debounce.sv
// Per-channel key debouncer for active-low pushbuttons feeding a Nios PIO.
// Optional press strobe: define KEY_PRESS_PULSE_EN to enable it. Otherwise key_press is constant 0.
module nios_adc_key_debounce #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_clean,
    output logic [WIDTH-1:0] key_press
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // The pins are asynchronous, so they pass through two flops before any logic sees them.
    // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             clean_q;

        // The counter only runs while the synchronized input disagrees with the output.
        // NOTE: these are per-channel registers, not a memory, so each one gets a reset value.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt     <= '0;
                clean_q <= 1'b1;
            end else if (sync2[i] == clean_q) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                clean_q <= sync2[i];
                cnt     <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end

        assign key_clean[i] = clean_q;
    end

`ifdef KEY_PRESS_PULSE_EN
    logic [WIDTH-1:0] key_clean_d;
    logic [WIDTH-1:0] key_press_q;

    // A falling edge of key_clean (1 -> 0) is a press. A release produces no strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_clean_d <= '1;
            key_press_q <= '0;
        end else begin
            key_clean_d <= key_clean;
            key_press_q <= key_clean_d & ~key_clean;
        end
    end

    assign key_press = key_press_q;
`else
    assign key_press = '0;
`endif

endmodule

// File: tb/tb_nios_adc_key_debounce.sv
// Directed bench for nios_adc_key_debounce (WIDTH=3, DEBOUNCE_CYCLES=16).
// Outputs are sampled 1 time unit after each rising edge, and inputs change at that same point.
module tb_nios_adc_key_debounce;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] key_raw;
    logic [2:0] key_clean;
    logic [2:0] key_press;

    int n_checks = 0;
    int n_errors = 0;

    nios_adc_key_debounce #(
        .WIDTH          (3),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .key_raw  (key_raw),
        .key_clean(key_clean),
        .key_press(key_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] strobe(input logic [2:0] v);
`ifdef KEY_PRESS_PULSE_EN
        return v;
`else
        return 3'b000 & v;
`endif
    endfunction

    // The input change (or reset release) has just been applied. The next edge is edge k.
    // key_clean must hold its old value through edge k+16 and take the new value at edge k+17.
    // The expected strobe appears at edge k+18 and lasts exactly one cycle.
    task automatic expect_change(input string tag, input logic [2:0] old_v,
                                 input logic [2:0] new_v, input logic [2:0] press_v);
        for (int j = 1; j <= 17; j++) begin
            tick();
            check({tag, "_hold"}, key_clean, old_v);
            check({tag, "_nopress"}, key_press, 3'b000);
        end
        tick();
        check({tag, "_clean"}, key_clean, new_v);
        check({tag, "_press_early"}, key_press, 3'b000);
        tick();
        check({tag, "_clean_k18"}, key_clean, new_v);
        check({tag, "_press"}, key_press, strobe(press_v));
        tick();
        check({tag, "_press_end"}, key_press, 3'b000);
    endtask

    task automatic hold_steady(input string tag, input int n, input logic [2:0] v);
        for (int j = 0; j < n; j++) begin
            tick();
            check({tag, "_clean"}, key_clean, v);
            check({tag, "_press"}, key_press, 3'b000);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        key_raw = 3'b111;
        tick();
        tick();
        check("reset_clean", key_clean, 3'b111);
        check("reset_press", key_press, 3'b000);
        reset_n = 1'b1;
        hold_steady("idle", 50, 3'b111);

        // Single-channel press, then release (release must not strobe).
        key_raw = 3'b110;
        expect_change("press0", 3'b111, 3'b110, 3'b001);
        key_raw = 3'b111;
        expect_change("rel0", 3'b110, 3'b111, 3'b000);

        // Bounce on key 1: low 10, high 3, then low and held.
        key_raw = 3'b101;
        hold_steady("bounce_lo", 10, 3'b111);
        key_raw = 3'b111;
        hold_steady("bounce_hi", 3, 3'b111);
        key_raw = 3'b101;
        expect_change("press1", 3'b111, 3'b101, 3'b010);
        key_raw = 3'b111;
        expect_change("rel1", 3'b101, 3'b111, 3'b000);

        // All channels change on the same edge.
        key_raw = 3'b000;
        expect_change("press_all", 3'b111, 3'b000, 3'b111);
        key_raw = 3'b111;
        expect_change("rel_all", 3'b000, 3'b111, 3'b000);

        // A 15-cycle glitch on key 2 is one cycle short of the threshold and must be ignored.
        key_raw = 3'b011;
        hold_steady("glitch_lo", 15, 3'b111);
        key_raw = 3'b111;
        hold_steady("glitch_after", 30, 3'b111);

        // Asynchronous reset while key_clean is low forces it back to ones at once.
        key_raw = 3'b110;
        expect_change("press_pre_rst", 3'b111, 3'b110, 3'b001);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_clean", key_clean, 3'b111);
        check("async_rst_press", key_press, 3'b000);
        tick();
        reset_n = 1'b1;
        // Key still held after reset release: reported at edge 18 with one strobe.
        expect_change("held_after_rst", 3'b111, 3'b110, 3'b001);
        key_raw = 3'b111;
        expect_change("rel_after_rst", 3'b110, 3'b111, 3'b000);

        // Reset pulse in the middle of a debounce (counter at 8).
        key_raw = 3'b110;
        for (int j = 0; j < 10; j++) tick();
        check("mid_clean", key_clean, 3'b111);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_clean", key_clean, 3'b111);
        check("mid_rst_press", key_press, 3'b000);
        tick();
        reset_n = 1'b1;
        expect_change("mid_rst_press0", 3'b111, 3'b110, 3'b001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
